// File: rtl/exec_unit_pkg.sv
// +----------------------------------------------------------------------+
// | exec_unit_pkg: shared types for the execution unit issue path.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package exec_unit_pkg;

  localparam int EXEC_PARAMS_W = 6;
  localparam int REG_IDX_W     = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    BLOCKED = 2'd2
  } issue_state_t;

  typedef struct packed {
    logic [EXEC_PARAMS_W-1:0] params;
    logic [REG_IDX_W-1:0]     rs1;
    logic [REG_IDX_W-1:0]     rs2;
    logic [REG_IDX_W-1:0]     rd;
    logic                     rs1_used;
    logic                     rs2_used;
    logic                     rd_we;
    logic                     is_long;
  } issue_op_t;

endpackage

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// +----------------------------------------------------------------------+
// | reg_scoreboard: pending-write bits per register, set wins over clear.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_i,
  input  logic [IDX_W-1:0]    set_idx_i,
  input  logic                clr_i,
  input  logic [IDX_W-1:0]    clr_idx_i,
  output logic [NUM_REGS-1:0] sb_o,
  output logic [NUM_REGS-1:0] pend_o
);

  logic [NUM_REGS-1:0] sb_q;
  logic [NUM_REGS-1:0] sb_d;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
    if (i == 0) begin : g_x0
      assign sb_d[i]   = 1'b0;
      assign pend_o[i] = 1'b0;
    end else begin : g_reg
      logic w_set;
      logic w_clr;
      assign w_set     = set_i && (set_idx_i == IDX_W'(i));
      assign w_clr     = clr_i && (clr_idx_i == IDX_W'(i));
      assign sb_d[i]   = w_set | (sb_q[i] & ~w_clr);
      // Same-cycle writeback already hides the bit from lookups.
      assign pend_o[i] = sb_q[i] & ~w_clr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  assign sb_o = sb_q;

endmodule

`default_nettype wire

// File: rtl/exec_issue_ctrl.sv
// +----------------------------------------------------------------------+
// | exec_issue_ctrl: single-entry issue buffer with RAW/WAW scoreboard.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module exec_issue_ctrl
  import exec_unit_pkg::*;
#(
  parameter int PARAMS_W    = EXEC_PARAMS_W,
  parameter int NUM_REGS    = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   dec_valid,
  output logic                   dec_ready,
  input  logic [PARAMS_W-1:0]    dec_params,
  input  logic [REG_IDX_W-1:0]   dec_rs1,
  input  logic [REG_IDX_W-1:0]   dec_rs2,
  input  logic [REG_IDX_W-1:0]   dec_rd,
  input  logic                   dec_rs1_used,
  input  logic                   dec_rs2_used,
  input  logic                   dec_rd_we,
  input  logic                   dec_long,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output logic [PARAMS_W-1:0]    iss_params,
  output logic [REG_IDX_W-1:0]   iss_rs1,
  output logic [REG_IDX_W-1:0]   iss_rs2,
  output logic [REG_IDX_W-1:0]   iss_rd,
  output logic                   iss_rd_we,
  input  logic                   wb_valid,
  input  logic [REG_IDX_W-1:0]   wb_rd,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   busy
);

  issue_state_t            state_q, state_d;
  issue_op_t               op_q, op_d;
  logic [STALL_CNT_W-1:0]  stall_q, stall_d;
  logic [NUM_REGS-1:0]     w_sb;
  logic [NUM_REGS-1:0]     w_pend;
  issue_op_t               w_dec_op;
  logic                    w_held;
  logic                    w_hazard;
  logic                    w_fire;
  logic                    w_accept;
  logic                    w_sb_set;

  assign w_dec_op = '{params:   dec_params,
                      rs1:      dec_rs1,
                      rs2:      dec_rs2,
                      rd:       dec_rd,
                      rs1_used: dec_rs1_used,
                      rs2_used: dec_rs2_used,
                      rd_we:    dec_rd_we,
                      is_long:  dec_long};

  assign w_held   = (state_q != IDLE);
  assign w_hazard = (op_q.rs1_used && w_pend[op_q.rs1]) ||
                    (op_q.rs2_used && w_pend[op_q.rs2]) ||
                    (op_q.rd_we    && w_pend[op_q.rd]);

  assign iss_valid = w_held && !w_hazard && !flush;
  assign w_fire    = iss_valid && iss_ready;
  assign dec_ready = !flush && (!w_held || w_fire);
  assign w_accept  = dec_valid && dec_ready;
  assign w_sb_set  = w_fire && op_q.rd_we && op_q.is_long;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (REG_IDX_W)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_i     (w_sb_set),
    .set_idx_i (op_q.rd),
    .clr_i     (wb_valid),
    .clr_idx_i (wb_rd),
    .sb_o      (w_sb),
    .pend_o    (w_pend)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    stall_d = stall_q;
    if (flush) begin
      state_d = IDLE;
    end else if (w_accept) begin
      op_d    = w_dec_op;
      state_d = HELD;
    end else if (w_fire) begin
      state_d = IDLE;
    end else if (w_held) begin
      state_d = w_hazard ? BLOCKED : HELD;
    end
    if (w_held && w_hazard && !flush && (stall_q != '1)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      stall_q <= stall_d;
    end
  end

  assign iss_params  = op_q.params;
  assign iss_rs1     = op_q.rs1;
  assign iss_rs2     = op_q.rs2;
  assign iss_rd      = op_q.rd;
  assign iss_rd_we   = op_q.rd_we;
  assign stall_count = stall_q;
  assign busy        = w_held || (|w_sb);

endmodule

`default_nettype wire

// File: tb/tb_exec_issue_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_exec_issue_ctrl: directed self-checking bench for exec_issue_ctrl.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_exec_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [5:0]  dec_params;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_rs1_used, dec_rs2_used, dec_rd_we, dec_long;
  logic        iss_valid;
  logic        iss_ready;
  logic [5:0]  iss_params;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_rd_we;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [15:0] stall_count;
  logic        busy;

  int checks;
  int failures;
  int exp_stall;

  exec_issue_ctrl #(
    .PARAMS_W    (6),
    .NUM_REGS    (32),
    .STALL_CNT_W (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_params   (dec_params),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rd       (dec_rd),
    .dec_rs1_used (dec_rs1_used),
    .dec_rs2_used (dec_rs2_used),
    .dec_rd_we    (dec_rd_we),
    .dec_long     (dec_long),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .iss_params   (iss_params),
    .iss_rs1      (iss_rs1),
    .iss_rs2      (iss_rs2),
    .iss_rd       (iss_rd),
    .iss_rd_we    (iss_rd_we),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .stall_count  (stall_count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs sampled 1 time unit later, well clear of either clock edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_op(input logic [5:0] p, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd,
                          input logic u1, input logic u2,
                          input logic we, input logic lg);
    dec_valid    = 1'b1;
    dec_params   = p;
    dec_rs1      = rs1;
    dec_rs2      = rs2;
    dec_rd       = rd;
    dec_rs1_used = u1;
    dec_rs2_used = u2;
    dec_rd_we    = we;
    dec_long     = lg;
  endtask

  task automatic no_op();
    dec_valid    = 1'b0;
    dec_params   = '0;
    dec_rs1      = '0;
    dec_rs2      = '0;
    dec_rd       = '0;
    dec_rs1_used = 1'b0;
    dec_rs2_used = 1'b0;
    dec_rd_we    = 1'b0;
    dec_long     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    iss_ready = 1'b1;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    no_op();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (iss_valid !== 1'b0) begin failures++; $display("FAIL reset_iss_valid: got %b want 0", iss_valid); end
    checks++;
    if (dec_ready !== 1'b1) begin failures++; $display("FAIL reset_dec_ready: got %b want 1", dec_ready); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (stall_count !== 16'd0) begin failures++; $display("FAIL reset_stall: got %0d want 0", stall_count); end
    checks++;
    if ({iss_params, iss_rs1, iss_rs2, iss_rd, iss_rd_we} !== 22'd0) begin
      failures++; $display("FAIL reset_payload: got %h want 0", {iss_params, iss_rs1, iss_rs2, iss_rd, iss_rd_we});
    end
    rst_n = 1'b1;
    exp_stall = 0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      tick();
      drive_op(6'(i + 1), 5'd2, 5'd3, 5'(i + 10), 1'b1, 1'b1, 1'b1, 1'b0);
      settle();
      checks++;
      if (dec_ready !== 1'b1) begin failures++; $display("FAIL b2b_dec_ready[%0d]: got %b want 1", i, dec_ready); end
      if (i > 0) begin
        checks++;
        if (iss_valid !== 1'b1 || iss_params !== 6'(i) || iss_rd !== 5'(i + 9)) begin
          failures++;
          $display("FAIL b2b_issue[%0d]: got v=%b p=%0d rd=%0d want v=1 p=%0d rd=%0d",
                   i, iss_valid, iss_params, iss_rd, i, i + 9);
        end
      end
    end
    tick();
    no_op();
    settle();
    checks++;
    if (iss_valid !== 1'b1 || iss_params !== 6'd4) begin
      failures++; $display("FAIL b2b_last: got v=%b p=%0d want v=1 p=4", iss_valid, iss_params);
    end
    tick();
    settle();
    checks++;
    if (iss_valid !== 1'b0 || busy !== 1'b0 || stall_count !== 16'd0) begin
      failures++; $display("FAIL b2b_drain: got v=%b busy=%b stall=%0d want 0 0 0", iss_valid, busy, stall_count);
    end
  endtask

  task automatic test_raw();
    tick();
    drive_op(6'd5, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive_op(6'd6, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    settle();
    checks++;
    if (iss_valid !== 1'b1 || iss_rd !== 5'd5) begin
      failures++; $display("FAIL raw_long_issue: got v=%b rd=%0d want v=1 rd=5", iss_valid, iss_rd);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      no_op();
      settle();
      checks++;
      if (iss_valid !== 1'b0 || dec_ready !== 1'b0) begin
        failures++; $display("FAIL raw_blocked[%0d]: got v=%b rdy=%b want 0 0", c, iss_valid, dec_ready);
      end
      exp_stall++;
    end
    tick();
    wb_valid = 1'b1;
    wb_rd    = 5'd5;
    settle();
    checks++;
    if (iss_valid !== 1'b1 || iss_params !== 6'd6) begin
      failures++; $display("FAIL raw_wb_bypass: got v=%b p=%0d want v=1 p=6", iss_valid, iss_params);
    end
    checks++;
    if (stall_count !== 16'(exp_stall)) begin
      failures++; $display("FAIL raw_stall: got %0d want %0d", stall_count, exp_stall);
    end
    tick();
    wb_valid = 1'b0;
    settle();
    checks++;
    if (iss_valid !== 1'b0 || busy !== 1'b0 || stall_count !== 16'(exp_stall)) begin
      failures++; $display("FAIL raw_after: got v=%b busy=%b stall=%0d want 0 0 %0d", iss_valid, busy, stall_count, exp_stall);
    end
  endtask

  task automatic test_waw();
    tick();
    drive_op(6'd7, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive_op(6'd8, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 2; c++) begin
      tick();
      no_op();
      settle();
      checks++;
      if (iss_valid !== 1'b0) begin failures++; $display("FAIL waw_blocked[%0d]: got v=%b want 0", c, iss_valid); end
      exp_stall++;
    end
    tick();
    wb_valid = 1'b1;
    wb_rd    = 5'd7;
    settle();
    checks++;
    if (iss_valid !== 1'b1 || iss_params !== 6'd8) begin
      failures++; $display("FAIL waw_release: got v=%b p=%0d want v=1 p=8", iss_valid, iss_params);
    end
    tick();
    wb_valid = 1'b0;
    settle();
    checks++;
    if (busy !== 1'b1 || iss_valid !== 1'b0) begin
      failures++; $display("FAIL waw_set_wins_busy: got busy=%b v=%b want 1 0", busy, iss_valid);
    end
    drive_op(6'd9, 5'd7, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    no_op();
    settle();
    checks++;
    if (iss_valid !== 1'b0) begin failures++; $display("FAIL waw_sb7_held: got v=%b want 0", iss_valid); end
    exp_stall++;
    tick();
    wb_valid = 1'b1;
    wb_rd    = 5'd7;
    settle();
    checks++;
    if (iss_valid !== 1'b1 || iss_params !== 6'd9) begin
      failures++; $display("FAIL waw_sb7_release: got v=%b p=%0d want v=1 p=9", iss_valid, iss_params);
    end
    tick();
    wb_valid = 1'b0;
    settle();
    checks++;
    if (busy !== 1'b0 || stall_count !== 16'(exp_stall)) begin
      failures++; $display("FAIL waw_drain: got busy=%b stall=%0d want 0 %0d", busy, stall_count, exp_stall);
    end
  endtask

  task automatic test_x0();
    drive_op(6'd10, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive_op(6'd11, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    no_op();
    settle();
    checks++;
    if (iss_valid !== 1'b1 || iss_params !== 6'd11) begin
      failures++; $display("FAIL x0_no_stall: got v=%b p=%0d want v=1 p=11", iss_valid, iss_params);
    end
    tick();
    settle();
    checks++;
    if (busy !== 1'b0 || stall_count !== 16'(exp_stall)) begin
      failures++; $display("FAIL x0_sb_clear: got busy=%b stall=%0d want 0 %0d", busy, stall_count, exp_stall);
    end
  endtask

  task automatic test_flush();
    drive_op(6'd12, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive_op(6'd13, 5'd9, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    no_op();
    settle();
    checks++;
    if (iss_valid !== 1'b0) begin failures++; $display("FAIL flush_pre_blocked: got v=%b want 0", iss_valid); end
    exp_stall++;
    tick();
    flush = 1'b1;
    drive_op(6'd14, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    checks++;
    if (iss_valid !== 1'b0 || dec_ready !== 1'b0) begin
      failures++; $display("FAIL flush_cycle: got v=%b rdy=%b want 0 0", iss_valid, dec_ready);
    end
    tick();
    flush = 1'b0;
    no_op();
    settle();
    checks++;
    if (iss_valid !== 1'b0 || dec_ready !== 1'b1 || busy !== 1'b1 || stall_count !== 16'(exp_stall)) begin
      failures++; $display("FAIL flush_idle: got v=%b rdy=%b busy=%b stall=%0d want 0 1 1 %0d",
                           iss_valid, dec_ready, busy, stall_count, exp_stall);
    end
    tick();
    wb_valid = 1'b1;
    wb_rd    = 5'd9;
    settle();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL flush_busy_pending: got %b want 1", busy); end
    tick();
    wb_valid = 1'b0;
    settle();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy_wb: got %b want 0", busy); end
  endtask

  task automatic test_saturate_and_reset();
    int bad;
    bad = 0;
    drive_op(6'd15, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive_op(6'd16, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    no_op();
    for (int c = 0; c < 65539; c++) begin
      settle();
      if (iss_valid !== 1'b0) bad++;
      tick();
    end
    settle();
    checks++;
    if (bad != 0) begin failures++; $display("FAIL sat_blocked: issued %0d times want 0", bad); end
    checks++;
    if (stall_count !== 16'hFFFF) begin failures++; $display("FAIL sat_value: got %h want ffff", stall_count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (stall_count !== 16'd0 || busy !== 1'b0 || iss_valid !== 1'b0 || dec_ready !== 1'b1) begin
      failures++; $display("FAIL async_reset: got stall=%h busy=%b v=%b rdy=%b want 0 0 0 1",
                           stall_count, busy, iss_valid, dec_ready);
    end
    checks++;
    if ({iss_params, iss_rs1, iss_rs2, iss_rd, iss_rd_we} !== 22'd0) begin
      failures++; $display("FAIL async_reset_payload: got %h want 0", {iss_params, iss_rs1, iss_rs2, iss_rd, iss_rd_we});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_back_to_back();
    test_raw();
    test_waw();
    test_x0();
    test_flush();
    test_saturate_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
